// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   // Step counter must hold the value WIDTH itself.
   function automatic int div_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift the remainder/quotient register left by
// one, trial-subtract the divisor from the upper half and either keep the
// difference (quotient bit 1) or restore (quotient bit 0).
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   d_reg,
   output logic [2*WIDTH-1:0] acc_next
);

   // The minuend is the shifted upper half including the bit shifted out of
   // the top, so divisors above 2^(WIDTH-1) still divide correctly.
   logic [WIDTH:0] minuend;
   logic [WIDTH:0] diff;

   assign minuend = acc[2*WIDTH-1:WIDTH-1];
   assign diff    = minuend - {1'b0, d_reg};

   // Select the restored or subtracted partial remainder and the quotient bit.
   always_comb begin
      // NOTE: default first so every path assigns acc_next and no latch is inferred.
      acc_next = {acc[2*WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
         acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
   end

endmodule : div_step

// File: rtl/divider_unit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: DIVIDER_DIVZERO_FAST_EN -- when defined, a zero
// divisor skips the shift-subtract loop and finishes straight from LOAD.
module divider_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = div_cnt_width(WIDTH);

   div_state_e         state;
   div_state_e         state_next;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   d_reg;
   logic [CW-1:0]      count;
   logic               start_ok;
   logic               last_step;

   assign start_ok  = start && ((state == IDLE) || (state == DONE));
   assign last_step = (state == RUN) && (count == CW'(1));

   assign busy = (state == LOAD) || (state == RUN);
   assign done = (state == DONE);

   div_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .d_reg    (d_reg),
      .acc_next (acc_next)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = LOAD;
`ifdef DIVIDER_DIVZERO_FAST_EN
         LOAD: state_next = (d_reg == '0) ? DONE : RUN;
`else
         LOAD: state_next = RUN;
`endif
         RUN:  if (count == CW'(1)) state_next = DONE;
         DONE: state_next = start ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, shift-subtract iteration and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the datapath is reset too, so an aborted operation leaves no
      // stale partial result and the outputs read zero out of reset.
      if (!rst_n) begin
         acc         <= '0;
         d_reg       <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (start_ok) begin
         d_reg <= divisor;
         acc   <= {{WIDTH{1'b0}}, dividend};
         count <= CW'(WIDTH);
      end else if (state == RUN) begin
         acc   <= acc_next;
         count <= count - CW'(1);
         if (last_step) begin
            quotient    <= acc_next[WIDTH-1:0];
            remainder   <= acc_next[2*WIDTH-1:WIDTH];
            div_by_zero <= (d_reg == '0);
         end
`ifdef DIVIDER_DIVZERO_FAST_EN
      end else if ((state == LOAD) && (d_reg == '0)) begin
         // Same results the full loop would produce for a zero divisor.
         quotient    <= '1;
         remainder   <= acc[WIDTH-1:0];
         div_by_zero <= 1'b1;
`endif
      end
   end

endmodule : divider_unit

// File: tb/tb_divider_unit.sv
// Directed self-checking bench for divider_unit (WIDTH = 32).
module tb_divider_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;
   logic [31:0] prev_q = '0;
   logic [31:0] prev_r = '0;

   localparam int LAT_FULL = 34;
`ifdef DIVIDER_DIVZERO_FAST_EN
   localparam int LAT_DZ = 2;
`else
   localparam int LAT_DZ = 34;
`endif

   divider_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Starts an operation at the current negedge and follows it to done.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int exp_lat,
                         input bit noisy, input string name);
      int n;
      bit found;
      n = 0;
      found = 1'b0;
      start = 1'b1;
      dividend = a;
      divisor = b;
      while (!found && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         start = 1'b0;
         if (noisy && (n == 5 || n == 20)) begin
            start = 1'b1;
            dividend = 32'd7;
            divisor = 32'd7;
         end
         if (n == 1) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy_in_load: got %b expected 1", name, busy);
            end
         end
         if (n == 10 && exp_lat > 10) begin
            checks++;
            if (quotient !== prev_q || remainder !== prev_r) begin
               errors++;
               $display("FAIL %s held_outputs: got q=%0h r=%0h expected q=%0h r=%0h",
                        name, quotient, remainder, prev_q, prev_r);
            end
         end
         if (done === 1'b1) found = 1'b1;
      end
      start = 1'b0;
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s done_seen: got none in %0d cycles expected done", name, n);
      end
      checks++;
      if (n != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
      end
      checks++;
      if (quotient !== eq) begin
         errors++;
         $display("FAIL %s quotient: got %0h expected %0h", name, quotient, eq);
      end
      checks++;
      if (remainder !== er) begin
         errors++;
         $display("FAIL %s remainder: got %0h expected %0h", name, remainder, er);
      end
      checks++;
      if (div_by_zero !== edz) begin
         errors++;
         $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, edz);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
      end
      prev_q = eq;
      prev_r = er;
   endtask

   // One cycle after done with start low: pulse over, idle, results held.
   task automatic check_after_done(input string name);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
      end
      checks++;
      if (quotient !== prev_q || remainder !== prev_r) begin
         errors++;
         $display("FAIL %s results_held: got q=%0h r=%0h expected q=%0h r=%0h",
                  name, quotient, remainder, prev_q, prev_r);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got busy=%b done=%b dz=%b expected 0 0 0",
                  busy, done, div_by_zero);
      end
      checks++;
      if (quotient !== 32'd0 || remainder !== 32'd0) begin
         errors++;
         $display("FAIL reset_results: got q=%0h r=%0h expected 0 0", quotient, remainder);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT_FULL, 1'b0, "100/7");
      check_after_done("100/7");
   endtask

   task automatic test_extremes();
      run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT_FULL, 1'b0, "max/1");
      check_after_done("max/1");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, LAT_FULL, 1'b0, "max/max");
      check_after_done("max/max");
      run_op(32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, LAT_FULL, 1'b0,
             "max/big");
      check_after_done("max/big");
      run_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, LAT_FULL, 1'b0, "3/10");
      check_after_done("3/10");
   endtask

   task automatic test_div_zero();
      run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, LAT_DZ, 1'b0, "5/0");
      check_after_done("5/0");
   endtask

   task automatic test_back_to_back();
      run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, LAT_FULL, 1'b1, "1000/3");
      run_op(32'd50, 32'd8, 32'd6, 32'd2, 1'b0, LAT_FULL, 1'b0, "50/8");
      check_after_done("50/8");
   endtask

   task automatic test_reset_mid_run();
      int dones;
      start = 1'b1;
      dividend = 32'd1000;
      divisor = 32'd3;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset_flags: got busy=%b done=%b dz=%b expected 0 0 0",
                  busy, done, div_by_zero);
      end
      checks++;
      if (quotient !== 32'd0 || remainder !== 32'd0) begin
         errors++;
         $display("FAIL midrun_reset_results: got q=%0h r=%0h expected 0 0",
                  quotient, remainder);
      end
      prev_q = '0;
      prev_r = '0;
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      checks++;
      if (dones != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrun_no_done: got dones=%0d busy=%b expected 0 0", dones, busy);
      end
      run_op(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, LAT_FULL, 1'b0, "9/4");
      check_after_done("9/4");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_divider_unit
